// File: rtl/prbs_config_sequencer.sv
// Shadow/active configuration registers for prbs_generator_top, with atomic
// commits at PRBS bit boundaries and an LFSR reseed pulse when required.
module prbs_config_sequencer #(
  parameter int unsigned MAX_PN_SEL     = 5,
  parameter int unsigned RESTART_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        dac_clk,
  input  logic        reset_n,
  input  logic        cfg_wr_en,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wr_data,
  input  logic        commit_req,
  input  logic        bit_boundary,
  output logic        commit_busy,
  output logic        commit_done,
  output logic        commit_timeout,
  output logic        cfg_error,
  input  logic        err_clr,
  output logic        gen_reset_n,
  output logic        prbs_mode_select,
  output logic [4:0]  prbs_pn_select_reg,
  output logic [31:0] prbs_bit_rate_config_reg,
  output logic [7:0]  prbs_edge_time_config_reg,
  output logic [15:0] prbs_amplitude_config_reg,
  output logic [15:0] prbs_dc_offset_config_reg
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_BND = 3'd1;
  localparam logic [2:0] APPLY    = 3'd2;
  localparam logic [2:0] RESTART  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > RESTART_CYCLES) ? TIMEOUT_CYCLES
                                                                      : RESTART_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [4:0]  PN_MAX  = 5'(MAX_PN_SEL);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, gen_rst_n_q, gen_rst_n_d;
  logic             apply_q, apply_d, err_q, err_d, tmo_q, tmo_d;

  logic             sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [4:0]       sh_pn_q, sh_pn_d, act_pn_q, act_pn_d;
  logic [31:0]      sh_rate_q, sh_rate_d, act_rate_q, act_rate_d;
  logic [7:0]       sh_edge_q, sh_edge_d, act_edge_q, act_edge_d;
  logic [15:0]      sh_amp_q, sh_amp_d, act_amp_q, act_amp_d;
  logic [15:0]      sh_ofs_q, sh_ofs_d, act_ofs_q, act_ofs_d;

  logic             wr_illegal, set_tmo;

  always_comb begin
    // NOTE: every _d takes its _q value first so no path through this block infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    set_tmo     = 1'b0;
    sh_mode_d   = sh_mode_q;
    sh_pn_d     = sh_pn_q;
    sh_rate_d   = sh_rate_q;
    sh_edge_d   = sh_edge_q;
    sh_amp_d    = sh_amp_q;
    sh_ofs_d    = sh_ofs_q;
    act_mode_d  = act_mode_q;
    act_pn_d    = act_pn_q;
    act_rate_d  = act_rate_q;
    act_edge_d  = act_edge_q;
    act_amp_d   = act_amp_q;
    act_ofs_d   = act_ofs_q;

    wr_illegal = cfg_wr_en && (busy_q || (cfg_addr > 3'd5) ||
                               ((cfg_addr == 3'd1) && (cfg_wr_data[4:0] > PN_MAX)));

    if (cfg_wr_en && !wr_illegal) begin
      case (cfg_addr)
        3'd0:    sh_mode_d = cfg_wr_data[0];
        3'd1:    sh_pn_d   = cfg_wr_data[4:0];
        3'd2:    sh_rate_d = cfg_wr_data;
        3'd3:    sh_edge_d = (cfg_wr_data[7:0] == 8'd0) ? 8'd1 : cfg_wr_data[7:0];
        3'd4:    sh_amp_d  = cfg_wr_data[15:0];
        default: sh_ofs_d  = cfg_wr_data[15:0];
      endcase
    end

    case (state_q)
      IDLE: begin
        if (commit_req) begin
          state_d = act_mode_q ? WAIT_BND : APPLY;
          cnt_d   = '0;
        end
      end
      WAIT_BND: begin
        if (bit_boundary) begin
          state_d = APPLY;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = APPLY;
          set_tmo = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      APPLY: begin
        // Reseed on a new polynomial or when PRBS output is being switched on.
        if ((sh_pn_q != act_pn_q) || (!act_mode_q && sh_mode_q)) begin
          state_d = RESTART;
          cnt_d   = '0;
        end else begin
          state_d = DONE;
        end
      end
      RESTART: begin
        if (cnt_q == CNT_W'(RESTART_CYCLES - 1)) state_d = DONE;
        else                                     cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The output stage trails the FSM by one cycle so every output is a flop.
    busy_d      = (state_d != IDLE);
    done_d      = (state_q == DONE);
    gen_rst_n_d = (state_q != RESTART);
    apply_d     = (state_q == APPLY);

    if (apply_q) begin
      act_mode_d = sh_mode_q;
      act_pn_d   = sh_pn_q;
      act_rate_d = sh_rate_q;
      act_edge_d = sh_edge_q;
      act_amp_d  = sh_amp_q;
      act_ofs_d  = sh_ofs_q;
    end

    if (err_clr) begin
      err_d = 1'b0;
      tmo_d = 1'b0;
    end else begin
      if (wr_illegal) err_d = 1'b1;
      if (set_tmo)    tmo_d = 1'b1;
    end
  end

  always_ff @(posedge dac_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      gen_rst_n_q <= 1'b1;
      apply_q     <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      sh_mode_q   <= 1'b0;
      sh_pn_q     <= 5'd0;
      sh_rate_q   <= 32'h4000_0000;
      sh_edge_q   <= 8'd2;
      sh_amp_q    <= 16'h8000;
      sh_ofs_q    <= 16'h0000;
      act_mode_q  <= 1'b0;
      act_pn_q    <= 5'd0;
      act_rate_q  <= 32'h4000_0000;
      act_edge_q  <= 8'd2;
      act_amp_q   <= 16'h8000;
      act_ofs_q   <= 16'h0000;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values together.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      gen_rst_n_q <= gen_rst_n_d;
      apply_q     <= apply_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      sh_mode_q   <= sh_mode_d;
      sh_pn_q     <= sh_pn_d;
      sh_rate_q   <= sh_rate_d;
      sh_edge_q   <= sh_edge_d;
      sh_amp_q    <= sh_amp_d;
      sh_ofs_q    <= sh_ofs_d;
      act_mode_q  <= act_mode_d;
      act_pn_q    <= act_pn_d;
      act_rate_q  <= act_rate_d;
      act_edge_q  <= act_edge_d;
      act_amp_q   <= act_amp_d;
      act_ofs_q   <= act_ofs_d;
    end
  end

  assign commit_busy               = busy_q;
  assign commit_done               = done_q;
  assign commit_timeout            = tmo_q;
  assign cfg_error                 = err_q;
  assign gen_reset_n               = gen_rst_n_q;
  assign prbs_mode_select          = act_mode_q;
  assign prbs_pn_select_reg        = act_pn_q;
  assign prbs_bit_rate_config_reg  = act_rate_q;
  assign prbs_edge_time_config_reg = act_edge_q;
  assign prbs_amplitude_config_reg = act_amp_q;
  assign prbs_dc_offset_config_reg = act_ofs_q;

endmodule

// File: doc/prbs_config_sequencer.md
Name: prbs_config_sequencer

Overview:
- Owns the active configuration registers that drive prbs_generator_top.
- Host writes go into shadow registers. On a commit request, all fields are transferred atomically at a PRBS bit boundary, so the generator never runs a bit period with a mixed configuration.
- Issues a generator restart pulse (LFSR reseed) when the PN polynomial changes or PRBS mode is enabled.
- Sits between the host register bus and prbs_generator_top in the dac_clk domain.

Parameters:
- MAX_PN_SEL, 5: highest legal PN select code.
- RESTART_CYCLES, 4: cycles gen_reset_n is held low on restart (≥1).
- TIMEOUT_CYCLES, 4096: maximum wait for bit_boundary before a forced apply (≥2).

Ports:
- dac_clk in 1: sole clock.
- reset_n in 1: asynchronous active-low reset.
- cfg_wr_en in 1: shadow write strobe, single cycle.
- cfg_addr in 3: shadow register select.
- cfg_wr_data in 32: write data.
- commit_req in 1: commit pulse.
- bit_boundary in 1: one-cycle pulse from the generator at each bit-period start.
- commit_busy out 1: high while a commit is in flight.
- commit_done out 1: one-cycle pulse when a commit completes.
- commit_timeout out 1: sticky; last commit was forced by timeout.
- cfg_error out 1: sticky illegal-access flag.
- err_clr in 1: clears cfg_error and commit_timeout.
- gen_reset_n out 1: active-low generator reseed.
- prbs_mode_select out 1: active register.
- prbs_pn_select_reg out 5: active register.
- prbs_bit_rate_config_reg out 32: active register.
- prbs_edge_time_config_reg out 8: active register.
- prbs_amplitude_config_reg out 16: active register.
- prbs_dc_offset_config_reg out 16: active register.

Behaviour:
- Reset values, active and shadow identical:
  - mode 0, pn 0, bit_rate 32'h40000000, edge 8'd2, amplitude 16'h8000, offset 0.
  - gen_reset_n 1, commit_busy 0, commit_done 0, cfg_error 0, commit_timeout 0.
  - State IDLE, counters 0.
- Reset mid-commit aborts the commit immediately. No done pulse is issued.
- Shadow address map, upper bits ignored:
  - 0: mode = data[0]
  - 1: pn = data[4:0]
  - 2: bit_rate = data[31:0]
  - 3: edge = data[7:0]
  - 4: amplitude = data[15:0]
  - 5: offset = data[15:0]
- Illegal accesses set cfg_error and leave the shadow unchanged:
  - write to addr 6 or 7;
  - pn > MAX_PN_SEL;
  - any write while commit_busy = 1.
- Edge value 0 is stored as 1 (clamp); this is not an error.
- err_clr has priority over setting cfg_error / commit_timeout in the same cycle.
- FSM states: IDLE, WAIT_BND, APPLY, RESTART, DONE.
  - IDLE: on commit_req, go to APPLY if active mode = 0, else go to WAIT_BND with the timeout counter cleared.
  - IDLE, same-cycle cfg_wr_en and commit_req: the write lands in the shadow and is included in the commit.
  - commit_req outside IDLE is ignored (no error, no queuing).
  - WAIT_BND: on bit_boundary, go to APPLY. If the counter reaches TIMEOUT_CYCLES-1 with no boundary, go to APPLY and set commit_timeout.
  - WAIT_BND: a boundary and the timeout in the same cycle counts as a boundary; commit_timeout is not set.
  - APPLY (one cycle): copy all six shadow fields to the active registers. Go to RESTART if pn changed OR mode goes 0→1; otherwise go to DONE.
  - RESTART: gen_reset_n = 0 for exactly RESTART_CYCLES cycles, then go to DONE.
  - DONE: commit_done = 1 for one cycle, then go to IDLE.
- commit_busy = (state != IDLE), registered with the state.
- Latency, mode 0, no restart: commit_req sampled at edge N → active registers and commit_done visible after edge N+2.
- Latency with restart: gen_reset_n is low after edges N+2 .. N+1+RESTART_CYCLES. commit_done is visible after edge N+2+RESTART_CYCLES.
- Mode 1→0 applies with no restart. gen_reset_n is otherwise constantly 1.
- All outputs are registered.

Test Plan:
- Reset defaults: after release, active registers read 0 / 0 / 0x40000000 / 2 / 0x8000 / 0, gen_reset_n = 1, commit_busy = 0.
- Write addr1 = 3, addr0 = 1, then commit with mode 0 → APPLY, then gen_reset_n low for 4 cycles. pn = 3 and mode = 1 change on the same edge. commit_done pulses once, 6 cycles after the commit_req sample.
- With mode 1, write bit_rate 0x20000000 and commit; bit_boundary arrives 37 cycles later → active bit_rate unchanged until that boundary + 1 edge, no gen_reset_n pulse, commit_timeout = 0.
- With mode 1, commit with no bit_boundary and TIMEOUT_CYCLES = 16 → forced apply after 16 WAIT_BND cycles, commit_timeout = 1. err_clr clears it.
- Illegal accesses: pn = 9, addr 6, a write during busy → cfg_error = 1, shadow unchanged, next commit leaves active pn unchanged. Edge write 0 then commit → edge = 1, cfg_error still 0 after err_clr.
- Assert reset_n low during RESTART → gen_reset_n = 1 immediately, active registers return to defaults, no commit_done.
